// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request scheduler.
// Holds the FSM state enumeration, the default sizes and the response-flag encoding.
package gcd_pkg;

    localparam int GCD_W       = 8;
    localparam int GCD_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_flags_t;

    localparam rsp_flags_t RSP_OK      = '{err: 1'b0, timeout: 1'b0};
    localparam rsp_flags_t RSP_ERR     = '{err: 1'b1, timeout: 1'b0};
    localparam rsp_flags_t RSP_TIMEOUT = '{err: 1'b1, timeout: 1'b1};

endpackage

// File: rtl/gcd_sched_if.sv
// Bundle of the requester, engine and response signals of gcd_sched.
// slave is the scheduler's view; master is the view of whatever drives requests and the engine.
interface gcd_sched_if
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) ();

    logic         req0_valid;
    logic         req1_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req0_ready;
    logic         req1_ready;

    logic         eng_start;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;
    logic [W-1:0] eng_y;
    logic         eng_done;
    logic         eng_error;

    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_y;
    logic         rsp_err;
    logic         rsp_timeout;
    logic         busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output eng_start, eng_a, eng_b,
        input  eng_y, eng_done, eng_error,
        output rsp_valid, rsp_id, rsp_y, rsp_err, rsp_timeout, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  eng_start, eng_a, eng_b,
        output eng_y, eng_done, eng_error,
        input  rsp_valid, rsp_id, rsp_y, rsp_err, rsp_timeout, busy
    );

endinterface

// File: rtl/gcd_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the pointer.
// The pointer moves to the other requester when a job finishes (done strobe).
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic rr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] & (~req[1-gi] | (rr_reg == 1'(gi)));
        end
    endgenerate

    assign gnt_id = gnt[1];

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_reg <= 1'b0;
        end else if (done) begin
            rr_reg <= ~done_id;
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Two-requester front end for a shared GCD engine: arbitrates, launches the engine,
// bounds its run time and returns one response per accepted request.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input logic        clk,
    input logic        rst,
    gcd_sched_if.slave bus
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t       state_reg;
    logic [7:0]   cnt_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         id_reg;
    logic         eng_start_reg;
    logic         rsp_valid_reg;
    logic         rsp_id_reg;
    logic [W-1:0] rsp_y_reg;
    rsp_flags_t   rsp_flags_reg;

    logic [1:0]   req_vec;
    logic [1:0]   gnt;
    logic         gnt_id;
    logic         is_idle;
    logic         accept;
    logic         job_done;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    assign req_vec  = {bus.req1_valid, bus.req0_valid};
    assign is_idle  = (state_reg == IDLE);
    assign accept   = is_idle && (gnt != 2'b00);
    assign job_done = (state_reg == RESP);
    assign op_a     = gnt_id ? bus.req1_a : bus.req0_a;
    assign op_b     = gnt_id ? bus.req1_b : bus.req0_b;

    rr_arb2 u_arb (
        .clk     (clk),
        .srst    (rst),
        .req     (req_vec),
        .done    (job_done),
        .done_id (id_reg),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    assign bus.req0_ready  = is_idle & gnt[0];
    assign bus.req1_ready  = is_idle & gnt[1];
    assign bus.eng_start   = eng_start_reg;
    assign bus.eng_a       = a_reg;
    assign bus.eng_b       = b_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_id      = rsp_id_reg;
    assign bus.rsp_y       = rsp_y_reg;
    assign bus.rsp_err     = rsp_flags_reg.err;
    assign bus.rsp_timeout = rsp_flags_reg.timeout;
    assign bus.busy        = ~is_idle;

    // Response fields are pulses: they default to zero every cycle and are
    // loaded only on the transition into RESP, so they read 0 whenever rsp_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= 1'b0;
            eng_start_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_y_reg     <= '0;
            rsp_flags_reg <= RSP_OK;
        end else begin
            eng_start_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_y_reg     <= '0;
            rsp_flags_reg <= RSP_OK;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        id_reg <= gnt_id;
                        if ((op_a == '0) || (op_b == '0)) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_id_reg    <= gnt_id;
                            rsp_flags_reg <= RSP_ERR;
                        end else begin
                            state_reg     <= LAUNCH;
                            eng_start_reg <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A completion in the last allowed cycle still beats the timeout.
                    if (bus.eng_done) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= id_reg;
                        rsp_y_reg     <= bus.eng_error ? '0 : bus.eng_y;
                        rsp_flags_reg <= bus.eng_error ? RSP_ERR : RSP_OK;
                    end else if (cnt_reg == WAIT_LAST) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= id_reg;
                        rsp_flags_reg <= RSP_TIMEOUT;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: a bench-side engine model, a per-cycle scoreboard
// built from cycle arithmetic on accepts/engine events, and literal checks of the key scenarios.
module tb_gcd_sched;

    localparam int W  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_sched_if #(.W(W)) bus ();

    gcd_sched #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gcd(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: answers gcd(eng_a, eng_b) eng_delay cycles after eng_start (0 = never).
    int eng_delay   = 0;
    bit eng_err_cfg = 1'b0;
    bit pulse_done  = 1'b0;
    int eng_rem     = 0;
    int ea, eb;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.eng_done  = 1'b0;
        bus.eng_error = 1'b0;
        bus.eng_y     = 8'hA5;
        if (rst) begin
            eng_rem = 0;
        end else begin
            if (eng_rem > 0) begin
                eng_rem--;
                if (eng_rem == 0) begin
                    bus.eng_done  = 1'b1;
                    bus.eng_error = eng_err_cfg;
                    bus.eng_y     = W'(gcd(ea, eb));
                end
            end
            if (bus.eng_start && eng_delay > 0) begin
                ea      = int'(bus.eng_a);
                eb      = int'(bus.eng_b);
                eng_rem = eng_delay;
            end
            if (pulse_done) begin
                bus.eng_done = 1'b1;
                bus.eng_y    = 8'd55;
                pulse_done   = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(output int rc);
        int n = 0;
        while (!bus.rsp_valid && n < 64) begin
            tick();
            n++;
        end
        check("rsp_seen", bus.rsp_valid, 1);
        rc = cyc;
        $display("[TB] rsp id=%0d y=%0d err=%0d timeout=%0d at cycle %0d",
                 bus.rsp_id, bus.rsp_y, bus.rsp_err, bus.rsp_timeout, cyc);
    endtask

    // Scoreboard: phase 0 idle, 1 engine running, 2 response scheduled.
    int   m_phase = 0;
    bit   m_rr = 1'b0;
    bit   m_on = 1'b0;
    bit   m_id = 1'b0;
    int   m_start = -1;
    int   m_resp = -1;
    int   m_a = 0, m_b = 0, m_y = 0;
    bit   m_err = 1'b0, m_to = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            begin : cmp_blk
                logic g0, g1, e_start, e_rv;
                g0 = (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || !m_rr);
                g1 = (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || m_rr);
                e_start = (m_phase != 0) && (cyc == m_start);
                e_rv    = (m_phase == 2) && (cyc == m_resp);
                if (m_on) begin
                    check("req0_ready", bus.req0_ready, g0);
                    check("req1_ready", bus.req1_ready, g1);
                    check("busy", bus.busy, (m_phase != 0));
                    check("eng_start", bus.eng_start, e_start);
                    check("rsp_valid", bus.rsp_valid, e_rv);
                    check("rsp_id", bus.rsp_id, e_rv ? m_id : 1'b0);
                    check("rsp_y", bus.rsp_y, e_rv ? m_y : 0);
                    check("rsp_err", bus.rsp_err, e_rv ? m_err : 1'b0);
                    check("rsp_timeout", bus.rsp_timeout, e_rv ? m_to : 1'b0);
                    if (e_start) begin
                        check("eng_a", bus.eng_a, m_a);
                        check("eng_b", bus.eng_b, m_b);
                    end
                end
                if (rst) begin
                    m_phase = 0;
                    m_rr    = 1'b0;
                    m_on    = 1'b1;
                end else begin
                    case (m_phase)
                        0: if (g0 || g1) begin
                            m_id = g1;
                            m_a  = g1 ? int'(bus.req1_a) : int'(bus.req0_a);
                            m_b  = g1 ? int'(bus.req1_b) : int'(bus.req0_b);
                            if (m_a == 0 || m_b == 0) begin
                                m_phase = 2; m_start = -1; m_resp = cyc + 1;
                                m_err = 1'b1; m_to = 1'b0; m_y = 0;
                            end else begin
                                m_phase = 1; m_start = cyc + 1;
                            end
                        end
                        1: if (cyc > m_start) begin
                            if (bus.eng_done) begin
                                m_phase = 2; m_resp = cyc + 1;
                                m_err = bus.eng_error; m_to = 1'b0;
                                m_y = bus.eng_error ? 0 : int'(bus.eng_y);
                            end else if (cyc == m_start + TO) begin
                                m_phase = 2; m_resp = cyc + 1;
                                m_err = 1'b1; m_to = 1'b1; m_y = 0;
                            end
                        end
                        2: if (cyc == m_resp) begin
                            m_phase = 0;
                            m_rr    = !m_id;
                        end
                        default: m_phase = 0;
                    endcase
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rc, seen;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.eng_y = '0; bus.eng_done = 1'b0; bus.eng_error = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_eng_start", bus.eng_start, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_eng_a", bus.eng_a, 0);

        // 48/18, engine answers after 5 WAIT cycles
        eng_delay = 5; eng_err_cfg = 1'b0;
        bus.req0_a = 8'd48; bus.req0_b = 8'd18; bus.req0_valid = 1'b1;
        #1; c0 = cyc;
        check("t1_ready0", bus.req0_ready, 1);
        tick(); bus.req0_valid = 1'b0;
        check("t1_start_cycle", bus.eng_start, 1);
        check("t1_eng_a", bus.eng_a, 48);
        check("t1_eng_b", bus.eng_b, 18);
        wait_rsp(rc);
        check("t1_latency", rc - c0, 7);
        check("t1_id", bus.rsp_id, 0);
        check("t1_y", bus.rsp_y, 6);
        check("t1_err", bus.rsp_err, 0);
        tick();

        // both valid after reset: req0 first, then req1, then req0 again
        rst = 1'b1; tick(); rst = 1'b0;
        eng_delay = 3;
        bus.req0_a = 8'd21; bus.req0_b = 8'd14; bus.req0_valid = 1'b1;
        bus.req1_a = 8'd36; bus.req1_b = 8'd24; bus.req1_valid = 1'b1;
        #1;
        check("t2_ready0", bus.req0_ready, 1);
        check("t2_ready1", bus.req1_ready, 0);
        tick(); bus.req0_valid = 1'b0;
        wait_rsp(rc);
        check("t2_first_id", bus.rsp_id, 0);
        check("t2_first_y", bus.rsp_y, 7);
        tick();
        check("t2_ready1_next", bus.req1_ready, 1);
        tick(); bus.req1_valid = 1'b0;
        wait_rsp(rc);
        check("t2_second_id", bus.rsp_id, 1);
        check("t2_second_y", bus.rsp_y, 12);
        tick();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("t2_rr_back_to_0", bus.req0_ready, 1);
        check("t2_rr_not_1", bus.req1_ready, 0);
        tick(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(rc);
        check("t2_third_y", bus.rsp_y, 7);
        tick();

        // zero operand from requester 1
        bus.req1_a = 8'd0; bus.req1_b = 8'd9; bus.req1_valid = 1'b1;
        #1; c0 = cyc;
        check("t3_ready1", bus.req1_ready, 1);
        tick(); bus.req1_valid = 1'b0;
        check("t3_no_start", bus.eng_start, 0);
        check("t3_rsp_valid", bus.rsp_valid, 1);
        check("t3_latency", cyc - c0, 1);
        check("t3_id", bus.rsp_id, 1);
        check("t3_err", bus.rsp_err, 1);
        check("t3_y", bus.rsp_y, 0);
        tick();

        // engine never answers -> timeout
        eng_delay = 0;
        bus.req0_a = 8'd5; bus.req0_b = 8'd10; bus.req0_valid = 1'b1;
        #1; c0 = cyc;
        tick(); bus.req0_valid = 1'b0;
        wait_rsp(rc);
        check("t4_latency", rc - c0, 18);
        check("t4_timeout", bus.rsp_timeout, 1);
        check("t4_err", bus.rsp_err, 1);
        check("t4_y", bus.rsp_y, 0);
        tick();
        eng_delay = 2;
        bus.req1_a = 8'd9; bus.req1_b = 8'd6; bus.req1_valid = 1'b1;
        #1;
        tick(); bus.req1_valid = 1'b0;
        wait_rsp(rc);
        check("t4_after_y", bus.rsp_y, 3);
        check("t4_after_timeout", bus.rsp_timeout, 0);
        tick();

        // done in the same cycle the timeout would fire
        eng_delay = TO;
        bus.req0_a = 8'd27; bus.req0_b = 8'd18; bus.req0_valid = 1'b1;
        #1; c0 = cyc;
        tick(); bus.req0_valid = 1'b0;
        wait_rsp(rc);
        check("t4b_latency", rc - c0, 18);
        check("t4b_timeout", bus.rsp_timeout, 0);
        check("t4b_y", bus.rsp_y, 9);
        tick();

        // reset during WAIT
        eng_delay = 10;
        bus.req0_a = 8'd100; bus.req0_b = 8'd75; bus.req0_valid = 1'b1;
        #1;
        tick(); bus.req0_valid = 1'b0;
        tick(); tick();
        check("t5_busy_before", bus.busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_busy", bus.busy, 0);
        check("t5_rsp_valid", bus.rsp_valid, 0);
        check("t5_eng_start", bus.eng_start, 0);
        check("t5_eng_a", bus.eng_a, 0);
        check("t5_rsp_y", bus.rsp_y, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        check("t5_no_aborted_rsp", seen, 0);
        eng_delay = 4;
        bus.req1_a = 8'd8; bus.req1_b = 8'd12; bus.req1_valid = 1'b1;
        #1;
        tick(); bus.req1_valid = 1'b0;
        wait_rsp(rc);
        check("t5_y", bus.rsp_y, 4);
        tick();

        // engine error with done, then a stray done in IDLE
        eng_delay = 3; eng_err_cfg = 1'b1;
        bus.req0_a = 8'd12; bus.req0_b = 8'd8; bus.req0_valid = 1'b1;
        #1;
        tick(); bus.req0_valid = 1'b0;
        wait_rsp(rc);
        check("t6_err", bus.rsp_err, 1);
        check("t6_y", bus.rsp_y, 0);
        eng_err_cfg = 1'b0;
        tick();
        pulse_done = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid || bus.busy) seen++;
        end
        check("t6_idle_done_ignored", seen, 0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_sched.md
GCD_SCHED -- requirements
Module: gcd_sched

Interface
REQ-001 Parameter W, default 8, operand/result width.
REQ-002 Parameter TIMEOUT, default 255, maximum engine WAIT cycles (range 1..255).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_valid, req1_valid  in  1 each  requester N has an operand pair.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  W each  operands of requester N.
REQ-007 req0_ready, req1_ready  out  1 each  requester N accepted this cycle (valid&ready).
REQ-008 eng_start  out  1  one-cycle launch pulse to the GCD engine.
REQ-009 eng_a, eng_b  out  W each  operands to the engine, held from LAUNCH until RESP.
REQ-010 eng_y  in  W  engine result.
REQ-011 eng_done, eng_error  in  1 each  engine completion and error flags.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rsp_id  out  1  requester index of the response.
REQ-014 rsp_y  out  W  GCD result.
REQ-015 rsp_err, rsp_timeout  out  1 each  error flag and timeout flag.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-018 Grant in IDLE: if only one valid, grant it; if both valid, grant the requester indicated by round-robin pointer rr.
REQ-019 reqN_ready = (state==IDLE) & grant==N, combinational; never both high.
REQ-020 On accept: latch operands and id; if either operand is 0, go to RESP with rsp_err=1, rsp_y=0, no eng_start; else go to LAUNCH.
REQ-021 LAUNCH: eng_start=1 for exactly one cycle; clear wait counter; next state WAIT.
REQ-022 WAIT: counter increments each cycle; eng_done=1 -> RESP capturing eng_y and eng_error; counter==TIMEOUT-1 without eng_done -> RESP with rsp_timeout=1, rsp_err=1, rsp_y=0.
REQ-023 eng_done and timeout in the same cycle: eng_done wins.
REQ-024 eng_error=1 with eng_done: rsp_err=1, rsp_y=0.
REQ-025 RESP: rsp_valid=1 for one cycle with the captured id/y/flags; rr set to the other requester; next state IDLE.
REQ-026 rsp_y/rsp_err/rsp_timeout/rsp_id are 0 whenever rsp_valid=0.
REQ-027 eng_done/eng_error outside WAIT are ignored.
REQ-028 Latency: accept at cycle 0, eng_start at cycle 1, eng_done seen at cycle k -> rsp_valid at k+1, next accept possible at k+2; zero-operand path -> rsp_valid at cycle 1.
REQ-029 A requester lowering valid while not granted loses nothing; no request is queued inside the block.

Reset
REQ-030 rst=1 at any clock edge forces IDLE, rr=0, counter=0, latched operands=0, all outputs 0, including mid-operation; no rsp_valid is issued for an aborted job.
REQ-031 The engine shares rst and is not separately aborted by this block.

Structure
REQ-032 Shared package gcd_pkg holds the state enumeration, the default W and TIMEOUT constants, and the response-flag type.
REQ-033 One sub-module, rr_arb2: 2-way round-robin grant with pointer update on a done strobe.

Verification
REQ-034 req0 48/18, engine model returns 6 after 5 WAIT cycles -> eng_start at cycle 1 with eng_a=48, eng_b=18; rsp_valid at cycle 7 with id=0, y=6, err=0.
REQ-035 Both valid after reset, req0 21/14, req1 36/24 -> req0 served first (y=7), then req1 (y=12); both valid again -> req0 granted.
REQ-036 req1 0/9 -> no eng_start; rsp_valid at cycle 1 with id=1, err=1, y=0.
REQ-037 TIMEOUT=16, engine never asserts done -> rsp_valid at cycle 18 with timeout=1, err=1, y=0; subsequent request is served normally.
REQ-038 rst pulsed during WAIT -> next cycle all outputs 0, no rsp_valid, busy=0; new request 8/12 then completes with y=4.
REQ-039 eng_done and eng_error both high in the same cycle -> rsp err=1, y=0; eng_done pulse during IDLE -> no response.
